// File: rtl/sysctrl_gen.sv
// MCU system-control slave: byte-serial command decoder driving LEDs, colour,
// an id-addressed config register file and a latched, maskable interrupt controller.
module sysctrl_gen #(
    parameter logic [7:0]            CORE_ID    = 8'h01,
    parameter logic [7:0]            IF_VERSION = 8'h02,
    parameter int                    NUM_VARS   = 26,
    parameter logic [8*NUM_VARS-1:0] VAR_RESET  = '0,
    parameter int                    INT_W      = 8,
    parameter int                    NUM_BTN    = 2,
    parameter int                    NUM_LED    = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    data_in_strobe,
    input  logic                    data_in_start,
    input  logic [7:0]              data_in,
    output logic [7:0]              data_out,
    output logic                    int_out_n,
    input  logic [INT_W-1:0]        int_in,
    input  logic [NUM_BTN-1:0]      buttons,
    output logic [NUM_LED-1:0]      leds,
    output logic [23:0]             color,
    output logic [8*NUM_VARS-1:0]   cfg_values,
    output logic [NUM_VARS-1:0]     cfg_changed
);

    localparam logic [7:0] CMD_ID      = 8'h00;
    localparam logic [7:0] CMD_LED     = 8'h01;
    localparam logic [7:0] CMD_COLOR   = 8'h02;
    localparam logic [7:0] CMD_BUTTONS = 8'h03;
    localparam logic [7:0] CMD_CFG_WR  = 8'h04;
    localparam logic [7:0] CMD_INT_ACK = 8'h05;
    localparam logic [7:0] CMD_MASK    = 8'h06;
    localparam logic [7:0] CMD_CFG_RD  = 8'h07;

    // Slot k answers to id byte "A"+k.
    localparam logic [7:0] ID_FIRST = 8'h41;

    logic [3:0]       state;
    logic [7:0]       command;
    logic [7:0]       id;
    logic [7:0]       cfg_mem [NUM_VARS];
    logic [INT_W-1:0] pending;
    logic [INT_W-1:0] mask;
    logic [INT_W-1:0] int_prev;
    logic [INT_W-1:0] ack;
    logic [7:0]       rd_value;
    logic             payload;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    assign payload = data_in_strobe && !data_in_start && (state != 4'd0);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        rd_value = 8'hff;
        for (int k = 0; k < NUM_VARS; k++)
            if (id == 8'(ID_FIRST + k)) rd_value = cfg_mem[k];
    end

    always_comb begin
        ack = '0;
        if (payload && state == 4'd1 && command == CMD_INT_ACK)
            ack = data_in[INT_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= 4'd0;
            command     <= 8'h00;
            id          <= 8'h00;
            data_out    <= 8'h00;
            leds        <= '0;
            color       <= 24'h0;
            mask        <= '1;
            cfg_changed <= '0;
            // NOTE: the config file is flops with per-slot reset values, not a RAM, so it is reset.
            for (int k = 0; k < NUM_VARS; k++) cfg_mem[k] <= VAR_RESET[8*k +: 8];
        end else begin
            cfg_changed <= '0;
            if (data_in_strobe && data_in_start) begin
                state   <= 4'd1;
                command <= data_in;
            end else if (payload) begin
                if (state != 4'hf) state <= state + 4'd1;
                case (command)
                    CMD_ID: begin
                        case (state)
                            4'd1:    data_out <= 8'h5c;
                            4'd2:    data_out <= 8'h42;
                            4'd3:    data_out <= CORE_ID;
                            4'd4:    data_out <= IF_VERSION;
                            default: data_out <= 8'h00;
                        endcase
                    end
                    CMD_LED: begin
                        if (state == 4'd1) leds <= data_in[NUM_LED-1:0];
                    end
                    CMD_COLOR: begin
                        case (state)
                            4'd1:    color[15:8]  <= rev8(data_in);
                            4'd2:    color[7:0]   <= rev8(data_in);
                            4'd3:    color[23:16] <= rev8(data_in);
                            default: ;
                        endcase
                    end
                    CMD_BUTTONS: data_out <= 8'(buttons);
                    CMD_CFG_WR: begin
                        if (state == 4'd1) begin
                            id <= data_in;
                        end else if (state == 4'd2) begin
                            for (int k = 0; k < NUM_VARS; k++) begin
                                if (id == 8'(ID_FIRST + k)) begin
                                    cfg_mem[k]     <= data_in;
                                    cfg_changed[k] <= 1'b1;
                                end
                            end
                        end
                    end
                    CMD_INT_ACK: data_out <= 8'(pending);
                    CMD_MASK: begin
                        if (state == 4'd1) mask <= data_in[INT_W-1:0];
                    end
                    CMD_CFG_RD: begin
                        if (state == 4'd1) begin
                            id       <= data_in;
                            data_out <= 8'h00;
                        end else if (state == 4'd2) begin
                            data_out <= rd_value;
                        end else begin
                            data_out <= 8'h00;
                        end
                    end
                    default: data_out <= 8'h00;
                endcase
            end
        end
    end

    // A new rising edge outranks an ack of the same bit in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= '0;
            int_prev  <= '0;
            int_out_n <= 1'b1;
        end else begin
            pending   <= (pending & ~ack) | (int_in & ~int_prev);
            int_prev  <= int_in;
            int_out_n <= ~|(pending & mask);
        end
    end

    for (genvar k = 0; k < NUM_VARS; k++) begin : g_cfg_out
        assign cfg_values[8*k +: 8] = cfg_mem[k];
    end

endmodule
